// File: rtl/icache_line_server_if.sv
// rtl/icache_line_server_if.sv - fetch line interface and refill memory port of the instruction cache
//
// Purpose: bundles the fetch-side line request/response signals and the
// memory-side refill handshake of icache_line_server.
// Ports (signals):
//   fetch_req, fetch_addr        fetch -> cache, line request
//   line_out, line_valid, miss   cache -> fetch, line response
//   mem_req, mem_addr            cache -> memory, refill request
//   mem_ack                      memory -> cache, request accepted
//   mem_data, mem_data_valid     memory -> cache, refill beats
// Modports: slave = the cache (responder), master = fetch/memory side.

interface icache_line_server_if #(
  parameter int WORD_SIZE  = 32,
  parameter int LINE_WORDS = 32,
  parameter int ADDR_W     = 32
);
  localparam int BLOCK_SIZE = WORD_SIZE * LINE_WORDS;

  logic                  fetch_req;
  logic [ADDR_W-1:0]     fetch_addr;
  logic [BLOCK_SIZE-1:0] line_out;
  logic                  line_valid;
  logic                  miss;
  logic                  mem_req;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_ack;
  logic [WORD_SIZE-1:0]  mem_data;
  logic                  mem_data_valid;

  modport slave (
    input  fetch_req, fetch_addr, mem_ack, mem_data, mem_data_valid,
    output line_out, line_valid, miss, mem_req, mem_addr
  );

  modport master (
    output fetch_req, fetch_addr, mem_ack, mem_data, mem_data_valid,
    input  line_out, line_valid, miss, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_line_server.sv
// rtl/icache_line_server.sv - direct-mapped instruction cache serving whole 32-word lines
//
// Purpose: answers fetch line requests from a direct-mapped array; a hit returns
// the line one cycle after the request, a miss refills the line one word per
// beat from the memory port and then returns it.
// Ports:
//   clk                     clock
//   rst                     synchronous active-high reset
//   bus (slave modport)     fetch line interface + refill memory port
//   hit_count, miss_count   saturating statistics, present only when the
//                           ICACHE_STATS_EN macro is defined

module icache_line_server #(
  parameter int WORD_SIZE  = 32,
  parameter int LINE_WORDS = 32,
  parameter int LINES      = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  icache_line_server_if.slave  bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam int BLOCK_SIZE = WORD_SIZE * LINE_WORDS;
  localparam int OFF_W      = $clog2(BLOCK_SIZE / 8);
  localparam int IDX_W      = $clog2(LINES);
  localparam int TAG_W      = ADDR_W - OFF_W - IDX_W;
  localparam int BEAT_W     = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  // Tag store and line array; only the valid bits need a reset value.
  logic [LINES-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag  [LINES];
  logic [BLOCK_SIZE-1:0] r_data [LINES];

  logic [BLOCK_SIZE-1:0] r_fill;
  logic [BEAT_W-1:0]     r_beat;
  logic [IDX_W-1:0]      r_idx;
  logic [TAG_W-1:0]      r_tag_lat;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [BLOCK_SIZE-1:0] r_line_out;
  logic                  r_line_valid;

  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_lookup_hit;
  logic                  w_hit;
  logic                  w_miss_det;
  logic                  w_ack;
  logic                  w_beat_en;
  logic                  w_last_beat;
  logic                  w_mem_req;
  logic                  w_miss;
  logic [BLOCK_SIZE-1:0] w_fill_next;
  logic                  w_unused_off;

  assign w_idx        = bus.fetch_addr[OFF_W+IDX_W-1:OFF_W];
  assign w_tag        = bus.fetch_addr[ADDR_W-1:OFF_W+IDX_W];
  assign w_lookup_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused_off = ^bus.fetch_addr[OFF_W-1:0];

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.fetch_req && !w_lookup_hit) w_state_next = S_REQ;
      S_REQ:   if (bus.mem_ack) w_state_next = S_FILL;
      S_FILL:  if (w_last_beat) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- state outputs
  always_comb begin
    w_hit       = 1'b0;
    w_miss_det  = 1'b0;
    w_ack       = 1'b0;
    w_beat_en   = 1'b0;
    w_last_beat = 1'b0;
    w_mem_req   = 1'b0;
    w_miss      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_hit      = bus.fetch_req && w_lookup_hit;
        w_miss_det = bus.fetch_req && !w_lookup_hit;
      end
      S_REQ: begin
        // Beats arriving before the ack are not part of this refill.
        w_mem_req = 1'b1;
        w_miss    = 1'b1;
        w_ack     = bus.mem_ack;
      end
      S_FILL: begin
        w_miss      = 1'b1;
        w_beat_en   = bus.mem_data_valid;
        w_last_beat = bus.mem_data_valid && (r_beat == BEAT_W'(LINE_WORDS - 1));
      end
      default: ;
    endcase
  end

  // Fill buffer with the current beat merged in, so the final beat can go
  // straight into the array and the response register in the same edge.
  always_comb begin
    w_fill_next = r_fill;
    for (int k = 0; k < LINE_WORDS; k++) begin
      if (w_beat_en && (r_beat == BEAT_W'(k))) begin
        w_fill_next[BLOCK_SIZE-1-WORD_SIZE*k -: WORD_SIZE] = bus.mem_data;
      end
    end
  end

  // ---------------------------------------------------------------- control datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= '0;
      r_line_valid <= 1'b0;
      r_line_out   <= '0;
      r_mem_addr   <= '0;
      r_beat       <= '0;
      r_idx        <= '0;
      r_tag_lat    <= '0;
    end else begin
      r_line_valid <= w_hit || w_last_beat;

      if (w_hit) begin
        r_line_out <= r_data[w_idx];
      end

      if (w_miss_det) begin
        r_mem_addr <= {bus.fetch_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        r_idx      <= w_idx;
        r_tag_lat  <= w_tag;
      end

      if (w_ack) begin
        r_beat <= '0;
      end else if (w_beat_en) begin
        r_beat <= r_beat + 1'b1;
      end

      if (w_last_beat) begin
        r_valid[r_idx] <= 1'b1;
        r_line_out     <= w_fill_next;
      end
    end
  end

  // Array storage: contents are meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (w_beat_en) begin
      r_fill <= w_fill_next;
    end
    if (w_last_beat) begin
      r_data[r_idx] <= w_fill_next;
      r_tag[r_idx]  <= r_tag_lat;
    end
  end

  assign bus.line_out   = r_line_out;
  assign bus.line_valid = r_line_valid;
  assign bus.miss       = w_miss;
  assign bus.mem_req    = w_mem_req;
  assign bus.mem_addr   = r_mem_addr;

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss_det && (r_miss_count != 32'hFFFF_FFFF)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule
